// File: rtl/lru_pkg.sv
// Shared helpers for the multi-set LRU tracker.
// Provides derived-width helpers and the reset rank image.
// The rank vector type is declared per instance from WAYS and WAY_W.
package lru_pkg;

  // Upper bound on the total bit width of one set's packed rank vector.
  localparam int MAX_RANK_BITS = 1024;

  // Index width for n entries. It is never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Packed rank vector with rank[w] = w. Each field is ww bits wide.
  // Way 0 is the lowest field.
  function automatic logic [MAX_RANK_BITS-1:0] reset_ranks(input int ways, input int ww);
    logic [MAX_RANK_BITS-1:0] v;
    v = '0;
    for (int i = 0; i < ways; i++) begin
      for (int b = 0; b < ww; b++) begin
        v[i*ww+b] = i[b];
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/lru_rank_update.sv
// Next-state rank and valid bits for one set, for a single access or invalidate.
// Purely combinational, with zero latency.
// It has no handshake. The caller decides whether to commit the result.
module lru_rank_update #(
  parameter int WAYS  = 8,
  parameter int WAY_W = 3
) (
  input  logic [WAYS*WAY_W-1:0] rank_in,
  input  logic [WAYS-1:0]       valid_in,
  input  logic                  inval,
  input  logic [WAY_W-1:0]      way,
  output logic [WAYS*WAY_W-1:0] rank_out,
  output logic [WAYS-1:0]       valid_out
);

  localparam logic [WAY_W-1:0] LRU_RANK = WAY_W'(WAYS - 1);

  logic [WAY_W-1:0] old_r;
  logic [WAY_W-1:0] cur;

  // An access promotes the way to MRU and ages every younger way by one.
  // An invalidate demotes the way to LRU and refreshes every older way by one.
  always_comb begin
    old_r     = '0;
    cur       = '0;
    rank_out  = rank_in;
    valid_out = valid_in;
    for (int i = 0; i < WAYS; i++) begin
      if (WAY_W'(i) == way) old_r = rank_in[i*WAY_W +: WAY_W];
    end
    for (int i = 0; i < WAYS; i++) begin
      cur = rank_in[i*WAY_W +: WAY_W];
      if (WAY_W'(i) == way) begin
        rank_out[i*WAY_W +: WAY_W] = inval ? LRU_RANK : '0;
        valid_out[i]               = !inval;
      end else if (!inval && (cur < old_r)) begin
        rank_out[i*WAY_W +: WAY_W] = cur + WAY_W'(1);
      end else if (inval && (cur > old_r)) begin
        rank_out[i*WAY_W +: WAY_W] = cur - WAY_W'(1);
      end
    end
  end

endmodule

// File: rtl/lru_multiset.sv
// Per-set LRU tracker with valid bits, invalid-first victim selection and a one-entry deferred invalidate.
// Updates land on the clock edge. victim_way and set_full are combinational from state and query_set.
// inval_ready drops while a deferred invalidate is parked. It returns the cycle after that invalidate is applied.
module lru_multiset
  import lru_pkg::*;
#(
  parameter int SETS  = 4,
  parameter int WAYS  = 8,
  parameter int SET_W = clog2_min1(SETS),
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             access,
  input  logic [SET_W-1:0] access_set,
  input  logic [WAY_W-1:0] access_way,
  input  logic             inval_v,
  output logic             inval_ready,
  input  logic [SET_W-1:0] inval_set,
  input  logic [WAY_W-1:0] inval_way,
  input  logic [SET_W-1:0] query_set,
  output logic [WAY_W-1:0] victim_way,
  output logic             set_full
);

  localparam int RB = WAYS * WAY_W;
  typedef logic [RB-1:0] rank_vec_t;

  localparam logic [MAX_RANK_BITS-1:0] RST_ALL  = reset_ranks(WAYS, WAY_W);
  localparam rank_vec_t                RST_RANK = RST_ALL[RB-1:0];
  localparam logic [WAY_W-1:0]         LRU_RANK = WAY_W'(WAYS - 1);

  rank_vec_t        rank_q  [SETS];
  logic [WAYS-1:0]  valid_q [SETS];

  logic             pend_v;
  logic [SET_W-1:0] pend_set;
  logic [WAY_W-1:0] pend_way;

  logic             acc_do, inv_do, inv_accept, inv_ok, capture, pend_hold;
  logic [SET_W-1:0] acc_idx, inv_idx;
  logic [WAY_W-1:0] inv_w;
  rank_vec_t        acc_rank, inv_rank;
  logic [WAYS-1:0]  acc_valid, inv_valid;

  // This output comes only from the pending register, so no input feeds it combinationally.
  assign inval_ready = !pend_v;

  // Choose the access update, and the single invalidate (pending or new) that may commit this cycle.
  always_comb begin
    acc_do     = access && ({1'b0, access_set} < (SET_W+1)'(SETS))
                        && ({1'b0, access_way} < (WAY_W+1)'(WAYS));
    acc_idx    = acc_do ? access_set : '0;
    inv_accept = inval_v && !pend_v;
    inv_ok     = ({1'b0, inval_set} < (SET_W+1)'(SETS))
              && ({1'b0, inval_way} < (WAY_W+1)'(WAYS));
    pend_hold  = access && (access_set == pend_set);
    capture    = inv_accept && inv_ok && access && (inval_set == access_set);
    inv_do     = 1'b0;
    inv_idx    = '0;
    inv_w      = '0;
    if (pend_v && !pend_hold) begin
      inv_do  = 1'b1;
      inv_idx = pend_set;
      inv_w   = pend_way;
    end else if (inv_accept && inv_ok && !capture) begin
      inv_do  = 1'b1;
      inv_idx = inval_set;
      inv_w   = inval_way;
    end
  end

  lru_rank_update #(.WAYS(WAYS), .WAY_W(WAY_W)) u_acc_upd (
    .rank_in   (rank_q[acc_idx]),
    .valid_in  (valid_q[acc_idx]),
    .inval     (1'b0),
    .way       (access_way),
    .rank_out  (acc_rank),
    .valid_out (acc_valid)
  );

  lru_rank_update #(.WAYS(WAYS), .WAY_W(WAY_W)) u_inv_upd (
    .rank_in   (rank_q[inv_idx]),
    .valid_in  (valid_q[inv_idx]),
    .inval     (1'b1),
    .way       (inv_w),
    .rank_out  (inv_rank),
    .valid_out (inv_valid)
  );

  // Set state: access and invalidate never target the same set in one cycle, so the priority order never matters.
  always_ff @(posedge clk) begin
    for (int s = 0; s < SETS; s++) begin
      if (rst) begin
        rank_q[s]  <= RST_RANK;
        valid_q[s] <= '0;
      end else if (acc_do && (acc_idx == SET_W'(s))) begin
        rank_q[s]  <= acc_rank;
        valid_q[s] <= acc_valid;
      end else if (inv_do && (inv_idx == SET_W'(s))) begin
        rank_q[s]  <= inv_rank;
        valid_q[s] <= inv_valid;
      end
    end
  end

  // Pending invalidate: park it when it collides with an access to its set, and drain it on the first free cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v   <= 1'b0;
      pend_set <= '0;
      pend_way <= '0;
    end else if (capture) begin
      pend_v   <= 1'b1;
      pend_set <= inval_set;
      pend_way <= inval_way;
    end else if (pend_v && !pend_hold) begin
      pend_v   <= 1'b0;
    end
  end

  logic             q_ok;
  logic [SET_W-1:0] q_idx;
  logic [WAY_W-1:0] first_inv, lru_way;

  // Victim: the lowest-index invalid way if there is one; otherwise the way holding the LRU rank.
  always_comb begin
    q_ok      = ({1'b0, query_set} < (SET_W+1)'(SETS));
    q_idx     = q_ok ? query_set : '0;
    first_inv = '0;
    lru_way   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_q[q_idx][i]) first_inv = WAY_W'(i);
    end
    for (int i = 0; i < WAYS; i++) begin
      if (rank_q[q_idx][i*WAY_W +: WAY_W] == LRU_RANK) lru_way = WAY_W'(i);
    end
    set_full   = q_ok && (&valid_q[q_idx]);
    victim_way = !q_ok ? '0 : (set_full ? lru_way : first_inv);
  end

endmodule

// File: tb/tb_lru_multiset.sv
// Self-checking bench for lru_multiset using directed and random steps.
// The reference model keeps each set as a recency list (front = MRU), plus valid flags and a pending slot.
// Every step checks inval_ready, and victim_way / set_full for every set.
module tb_lru_multiset;
  localparam int SETS  = 4;
  localparam int WAYS  = 8;
  localparam int SET_W = 2;
  localparam int WAY_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             access = 1'b0;
  logic [SET_W-1:0] access_set = '0;
  logic [WAY_W-1:0] access_way = '0;
  logic             inval_v = 1'b0;
  logic             inval_ready;
  logic [SET_W-1:0] inval_set = '0;
  logic [WAY_W-1:0] inval_way = '0;
  logic [SET_W-1:0] query_set = '0;
  logic [WAY_W-1:0] victim_way;
  logic             set_full;

  int tests = 0;
  int fails = 0;

  // Reference model
  int lst [SETS][$];
  bit mval [SETS][WAYS];
  bit mp_v;
  int mp_s, mp_w;

  lru_multiset #(.SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .rst(rst), .access(access), .access_set(access_set),
    .access_way(access_way), .inval_v(inval_v), .inval_ready(inval_ready),
    .inval_set(inval_set), .inval_way(inval_way), .query_set(query_set),
    .victim_way(victim_way), .set_full(set_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    mp_v = 0;
    for (int s = 0; s < SETS; s++) begin
      lst[s].delete();
      for (int w = 0; w < WAYS; w++) begin
        lst[s].push_back(w);
        mval[s][w] = 0;
      end
    end
  endtask

  task automatic m_touch(input int s, input int w, input bit inv);
    int idx;
    idx = -1;
    for (int i = 0; i < lst[s].size(); i++) if (lst[s][i] == w) idx = i;
    lst[s].delete(idx);
    if (inv) begin
      lst[s].push_back(w);
      mval[s][w] = 0;
    end else begin
      lst[s].push_front(w);
      mval[s][w] = 1;
    end
  endtask

  function automatic int exp_victim(input int s);
    for (int w = 0; w < WAYS; w++) if (!mval[s][w]) return w;
    return lst[s][WAYS-1];
  endfunction

  function automatic int exp_full(input int s);
    for (int w = 0; w < WAYS; w++) if (!mval[s][w]) return 0;
    return 1;
  endfunction

  task automatic m_edge(input bit a, input int as, input int aw, input bit iv, input int is, input int iw);
    if (rst) begin
      m_reset();
    end else begin
      if (mp_v) begin
        if (!(a && as == mp_s)) begin
          m_touch(mp_s, mp_w, 1);
          mp_v = 0;
        end
      end else if (iv) begin
        if (a && is == as) begin
          mp_v = 1; mp_s = is; mp_w = iw;
        end else begin
          m_touch(is, iw, 1);
        end
      end
      if (a) m_touch(as, aw, 0);
    end
  endtask

  task automatic check_all();
    chk("inval_ready", {31'b0, inval_ready}, {31'b0, !mp_v});
    for (int s = 0; s < SETS; s++) begin
      query_set = SET_W'(s);
      #1;
      chk($sformatf("victim_way set%0d", s), {29'b0, victim_way}, exp_victim(s));
      chk($sformatf("set_full set%0d", s), {31'b0, set_full}, exp_full(s));
    end
  endtask

  task automatic step(input bit a, input int as, input int aw, input bit iv, input int is, input int iw);
    access = a; access_set = SET_W'(as); access_way = WAY_W'(aw);
    inval_v = iv; inval_set = SET_W'(is); inval_way = WAY_W'(iw);
    @(posedge clk);
    m_edge(a, as, aw, iv, is, iw);
    #1;
    access = 0; inval_v = 0;
    check_all();
  endtask

  task automatic qchk(input string tag, input int s, input int vic, input int full);
    query_set = SET_W'(s);
    #1;
    chk({tag, " victim"}, {29'b0, victim_way}, vic);
    chk({tag, " full"}, {31'b0, set_full}, full);
  endtask

  initial begin
    m_reset();
    // Reset
    rst = 1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    rst = 0;
    for (int s = 0; s < SETS; s++) qchk("reset", s, 0, 0);
    chk("reset inval_ready", {31'b0, inval_ready}, 1);

    // Set 2: fill in descending order, so way 7 is the LRU
    for (int w = 7; w >= 0; w--) step(1, 2, w, 0, 0, 0);
    qchk("set2 filled", 2, 7, 1);
    step(1, 2, 7, 0, 0, 0);
    qchk("set2 touch7", 2, 6, 1);
    qchk("set0 untouched", 0, 0, 0);

    // Set 1: fill, invalidate way 3, then refill it
    for (int w = 0; w < 8; w++) step(1, 1, w, 0, 0, 0);
    step(0, 0, 0, 1, 1, 3);
    qchk("set1 inval3", 1, 3, 0);
    step(1, 1, 3, 0, 0, 0);
    qchk("set1 refill3", 1, 0, 1);

    // Collision: the invalidate is deferred for one cycle
    step(1, 1, 5, 1, 1, 5);
    chk("conflict ready low", {31'b0, inval_ready}, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("conflict ready back", {31'b0, inval_ready}, 1);
    qchk("conflict applied", 1, 5, 0);

    // Pending is held by repeated accesses, then drains alongside an access to set 3
    step(1, 1, 2, 1, 1, 6);
    step(1, 1, 5, 0, 0, 0);
    chk("hold ready 1", {31'b0, inval_ready}, 0);
    step(1, 1, 1, 0, 0, 0);
    chk("hold ready 2", {31'b0, inval_ready}, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("hold ready 3", {31'b0, inval_ready}, 0);
    step(1, 3, 4, 0, 0, 0);
    chk("drain ready", {31'b0, inval_ready}, 1);
    qchk("drain set1", 1, 6, 0);

    // Reset while an invalidate is pending and sets are partly filled
    step(1, 0, 1, 1, 0, 1);
    chk("pre-rst pending", {31'b0, inval_ready}, 0);
    rst = 1;
    step(0, 0, 0, 0, 0, 0);
    rst = 0;
    for (int s = 0; s < SETS; s++) qchk("mid rst", s, 0, 0);
    step(1, 0, 4, 0, 0, 0);
    qchk("post rst access4", 0, 0, 0);
    // Way 4 is MRU: fill every other way, and way 4 should end up LRU only after it is passed over
    for (int w = 0; w < 8; w++) if (w != 4) step(1, 0, w, 0, 0, 0);
    qchk("way4 oldest", 0, 4, 1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, SETS-1), $urandom_range(0, WAYS-1),
           $urandom_range(0, 2) == 0, $urandom_range(0, SETS-1), $urandom_range(0, WAYS-1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
